// File: rtl/radix_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radix_divider_pkg
// Description : Shared types and elaboration-time helpers for radix_divider.
//               Holds the FSM state encoding, the CALC iteration count and
//               the parameter legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package radix_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Number of CALC cycles needed to retire every quotient bit.
  function automatic int iter_count(input int dividend_width, input int bits_per_cycle);
    return dividend_width / bits_per_cycle;
  endfunction

  // Returns 1 when the parameter set describes a buildable divider.
  function automatic bit params_legal(input int dividend_width, input int divisor_width,
                                      input int bits_per_cycle, input int tag_width);
    bit ok;
    ok = 1'b1;
    if (divisor_width < 1 || divisor_width > dividend_width) ok = 1'b0;
    if (bits_per_cycle != 1 && bits_per_cycle != 2 && bits_per_cycle != 4) ok = 1'b0;
    if (bits_per_cycle > 0 && (dividend_width % bits_per_cycle) != 0) ok = 1'b0;
    if (dividend_width < 2 || tag_width < 1) ok = 1'b0;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix_divider_step.sv
`default_nettype none
// ============================================================================
// Module      : radix_divider_step
// Description : One combinational restoring division step. Shifts the next
//               dividend bit (MSB of quo_in) into the partial remainder,
//               subtracts the divisor when it fits and shifts the resulting
//               quotient bit into the LSB of quo_out.
// Ports       : partial_in/partial_out - DIVISOR_WIDTH+1 bit partial remainder
//               quo_in/quo_out         - dividend bits in, quotient bits out
//               divisor_mag            - divisor magnitude
// Revision    : 1.0 - initial release
// ============================================================================
module radix_divider_step #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 32
) (
  input  logic [DIVISOR_WIDTH:0]    partial_in,
  input  logic [DIVIDEND_WIDTH-1:0] quo_in,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_mag,
  output logic [DIVISOR_WIDTH:0]    partial_out,
  output logic [DIVIDEND_WIDTH-1:0] quo_out
);

  logic [DIVISOR_WIDTH:0] w_shifted;
  logic [DIVISOR_WIDTH:0] w_diff;
  logic                   w_fits;

  assign w_shifted = {partial_in[DIVISOR_WIDTH-1:0], quo_in[DIVIDEND_WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, divisor_mag};
  // A set top bit means the shifted value carried past DIVISOR_WIDTH+1 bits,
  // which always exceeds the divisor.
  assign w_fits    = partial_in[DIVISOR_WIDTH] || (w_shifted >= {1'b0, divisor_mag});

  assign partial_out = w_fits ? w_diff : w_shifted;
  assign quo_out     = {quo_in[DIVIDEND_WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/radix_divider.sv
`default_nettype none
// ============================================================================
// Module      : radix_divider
// Description : Multi-cycle restoring divider, signed or unsigned, retiring
//               BITS_PER_CYCLE quotient bits per CALC cycle. Zero divisor and
//               signed overflow bypass CALC and complete in one edge.
// Ports       : clock/reset (async, active-high)
//               in_valid/in_ready, in_signed, dividend, divisor, in_tag
//               out_valid/out_ready, quotient, remainder, out_tag,
//               div_by_zero, overflow
// Revision    : 1.0 - initial release
// ============================================================================
module radix_divider
  import radix_divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_signed,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic [TAG_WIDTH-1:0]      out_tag,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int C_ITER    = iter_count(DIVIDEND_WIDTH, BITS_PER_CYCLE);
  localparam int C_CNT_W   = $clog2(C_ITER + 1);

  generate
    if (!params_legal(DIVIDEND_WIDTH, DIVISOR_WIDTH, BITS_PER_CYCLE, TAG_WIDTH)) begin : g_param_check
      $error("radix_divider: illegal parameter combination");
    end
  endgenerate

  div_state_t r_state;
  div_state_t w_next_state;

  logic [DIVISOR_WIDTH:0]    r_partial;
  logic [DIVIDEND_WIDTH-1:0] r_quo;
  logic [DIVISOR_WIDTH-1:0]  r_divisor_mag;
  logic [C_CNT_W-1:0]        r_count;
  logic                      r_q_neg;
  logic                      r_r_neg;
  logic [TAG_WIDTH-1:0]      r_tag;

  logic                      w_accept;
  logic                      w_div_zero;
  logic                      w_overflow;
  logic                      w_dividend_neg;
  logic                      w_divisor_neg;
  logic [DIVIDEND_WIDTH-1:0] w_dividend_mag;
  logic [DIVISOR_WIDTH-1:0]  w_divisor_mag;
  logic [DIVISOR_WIDTH-1:0]  w_rem_mag;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;

  assign w_dividend_neg = in_signed && dividend[DIVIDEND_WIDTH-1];
  assign w_divisor_neg  = in_signed && divisor[DIVISOR_WIDTH-1];
  // The most-negative dividend negates to itself, which is still the correct
  // unsigned magnitude.
  assign w_dividend_mag = w_dividend_neg ? (~dividend + 1'b1) : dividend;
  assign w_divisor_mag  = w_divisor_neg  ? (~divisor + 1'b1)  : divisor;
  assign w_div_zero     = (divisor == '0);
  assign w_overflow     = in_signed
                       && (dividend == {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}})
                       && (divisor == '1);

  // Chain of restoring steps evaluated in a single CALC cycle.
  logic [DIVISOR_WIDTH:0]    w_partial [0:BITS_PER_CYCLE];
  logic [DIVIDEND_WIDTH-1:0] w_quo     [0:BITS_PER_CYCLE];

  assign w_partial[0] = r_partial;
  assign w_quo[0]     = r_quo;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      radix_divider_step #(
        .DIVIDEND_WIDTH(DIVIDEND_WIDTH),
        .DIVISOR_WIDTH (DIVISOR_WIDTH)
      ) u_step (
        .partial_in (w_partial[gi]),
        .quo_in     (w_quo[gi]),
        .divisor_mag(r_divisor_mag),
        .partial_out(w_partial[gi+1]),
        .quo_out    (w_quo[gi+1])
      );
    end
  endgenerate

  assign w_rem_mag = r_partial[DIVISOR_WIDTH-1:0];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next_state = (w_div_zero || w_overflow) ? DONE : CALC;
      CALC: if (r_count == C_CNT_W'(1)) w_next_state = FIX;
      FIX:  w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_partial     <= '0;
      r_quo         <= '0;
      r_divisor_mag <= '0;
      r_count       <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_tag         <= '0;
      quotient      <= '0;
      remainder     <= '0;
      out_tag       <= '0;
      div_by_zero   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tag <= in_tag;
            if (w_div_zero) begin
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_WIDTH-1:0];
              out_tag     <= in_tag;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (w_overflow) begin
              quotient    <= dividend;
              remainder   <= '0;
              out_tag     <= in_tag;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              r_partial     <= '0;
              r_quo         <= w_dividend_mag;
              r_divisor_mag <= w_divisor_mag;
              r_count       <= C_CNT_W'(C_ITER);
              r_q_neg       <= w_dividend_neg ^ w_divisor_neg;
              r_r_neg       <= w_dividend_neg;
            end
          end
        end
        CALC: begin
          r_partial <= w_partial[BITS_PER_CYCLE];
          r_quo     <= w_quo[BITS_PER_CYCLE];
          r_count   <= r_count - 1'b1;
        end
        FIX: begin
          quotient    <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
          remainder   <= r_r_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
          out_tag     <= r_tag;
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_radix_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix_divider
// Description : Self-checking bench for radix_divider (DW=32, DS=16, BPC=2)
//               with directed cases and randomized operations compared to an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix_divider;

  localparam int DW  = 32;
  localparam int DS  = 16;
  localparam int BPC = 2;
  localparam int TW  = 8;
  localparam int C_NORMAL_LAT = DW / BPC + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [DW-1:0] dividend;
  logic [DS-1:0] divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [DS-1:0] remainder;
  logic [TW-1:0] out_tag;
  logic          div_by_zero;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  radix_divider #(
    .DIVIDEND_WIDTH(DW),
    .DIVISOR_WIDTH (DS),
    .BITS_PER_CYCLE(BPC),
    .TAG_WIDTH     (TW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .out_tag    (out_tag),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit integers. SystemVerilog
  // signed / and % truncate toward zero with the remainder taking the
  // dividend's sign.
  task automatic ref_model(input bit sgn, input logic [DW-1:0] a, input logic [DS-1:0] b,
                           output logic [DW-1:0] q, output logic [DS-1:0] r,
                           output bit dz, output bit ov);
    longint sa, sb, lq, lr;
    dz = 0; ov = 0;
    if (b == 0) begin
      q = '1; r = a[DS-1:0]; dz = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 16'hFFFF) begin
      q = a; r = '0; ov = 1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({48'd0, b});
      end
      lq = sa / sb;
      lr = sa % sb;
      q = lq[DW-1:0];
      r = lr[DS-1:0];
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clock); #1; guard++;
    end
    check_eq("in_ready_wait", {63'd0, in_ready}, 64'd1);
  endtask

  // Issue one operation, check latency/results, hold out_ready low for
  // `hold` cycles in DONE, then complete the handshake.
  task automatic run_op(input bit sgn, input logic [DW-1:0] a, input logic [DS-1:0] b,
                        input logic [TW-1:0] tag, input int hold);
    logic [DW-1:0] eq;
    logic [DS-1:0] er;
    bit edz, eov;
    int lat;
    int exp_lat;
    ref_model(sgn, a, b, eq, er, edz, eov);
    exp_lat = (edz || eov) ? 1 : C_NORMAL_LAT;
    wait_ready();
    in_valid = 1; in_signed = sgn; dividend = a; divisor = b; in_tag = tag;
    @(posedge clock); #1;
    // Scramble inputs to confirm they were captured on the accepting edge.
    in_valid = 0; in_signed = ~sgn; dividend = $urandom; divisor = 16'($urandom); in_tag = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("quotient", 64'(quotient), 64'(eq));
    check_eq("remainder", 64'(remainder), 64'(er));
    check_eq("out_tag", 64'(out_tag), 64'(tag));
    check_eq("flags", {62'd0, div_by_zero, overflow}, {62'd0, edz, eov});
    check_eq("in_ready_done", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
      check_eq("hold_q", 64'(quotient), 64'(eq));
      check_eq("hold_r_tag", {40'd0, out_tag, remainder}, {40'd0, tag, er});
      check_eq("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1;
    @(posedge clock); #1;
    out_ready = 0;
    check_eq("after_handshake", {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [DW-1:0] a;
    logic [DS-1:0] b;
    reset = 1; in_valid = 0; in_signed = 0; dividend = '0; divisor = '0;
    in_tag = '0; out_ready = 0;
    #12;
    check_eq("reset_outputs", {quotient, remainder, out_tag, div_by_zero, overflow}, 64'd0);
    check_eq("reset_handshake", {62'd0, in_ready, out_valid}, 64'b10);
    @(posedge clock); #1;
    reset = 0;

    // Directed cases
    run_op(0, 32'd100, 16'd7, 8'h5A, 0);
    run_op(1, -32'sd100, 16'd7, 8'h11, 1);
    run_op(1, 32'd100, -16'sd7, 8'h22, 0);
    run_op(0, 32'h1234, 16'd0, 8'h33, 0);
    run_op(1, 32'h8000_0000, 16'hFFFF, 8'h44, 0);
    run_op(1, 32'h8000_0000, 16'd0, 8'h45, 0);   // zero divisor wins over overflow
    run_op(0, 32'h8000_0000, 16'hFFFF, 8'h46, 0); // unsigned: no overflow
    run_op(0, 32'hFFFF_FFFF, 16'd1, 8'h47, 5);
    run_op(0, 32'd5, 16'hFFFF, 8'h48, 0);

    // Reset in the middle of CALC
    wait_ready();
    in_valid = 1; in_signed = 0; dividend = 32'd100; divisor = 16'd7; in_tag = 8'h77;
    @(posedge clock); #1;
    in_valid = 0;
    repeat (7) @(posedge clock);
    #2 reset = 1;
    #1;
    check_eq("midreset_outputs", {quotient, remainder, out_tag, div_by_zero, overflow}, 64'd0);
    check_eq("midreset_handshake", {62'd0, in_ready, out_valid}, 64'b10);
    @(posedge clock); #1;
    reset = 0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (out_valid) pulses++;
    end
    check_eq("no_valid_after_reset", 64'(pulses), 64'd0);
    run_op(0, 32'd50, 16'd5, 8'h78, 0);

    // Randomized operations
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 300));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = '1;
        2:       b = 16'($urandom_range(1, 9));
        default: b = 16'($urandom);
      endcase
      run_op(1'($urandom_range(0, 1)), a, b, 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
